fetch_next_pc: RTL and testbench

Fetch-side companion to the program counter. It drives the program counter's next-address input and owns the IF/ID pipeline register. It selects the next PC: sequential, jump from ID, or taken branch from EX. It holds on load-use stalls and instruction-memory wait states, and latches a redirect that arrives while a fetch is outstanding so it can be applied once the fetch completes. It also squashes wrong-path instructions by clearing `ifid_valid`.

---
 rtl/fetch_next_pc.sv | 135 +++++++++++++
 tb/tb_fetch_next_pc.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_next_pc.sv
// Next-PC selection and IF/ID pipeline register for the fetch stage.
// Chooses between sequential, jump (ID) and taken-branch (EX) targets, holds on
// stalls and memory wait states, and parks a redirect that arrives during an
// outstanding fetch until that fetch completes.
module fetch_next_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc_in,
    input  logic [31:0] i_instr_in,
    input  logic        i_imem_ready,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    output logic [31:0] o_pc_next,
    output logic [31:0] o_ifid_instr,
    output logic [31:0] o_ifid_pc4,
    output logic        o_ifid_valid,
    output logic        o_redirect_pending
);

    typedef enum logic {
        StRun,
        StHoldRedir
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [31:0] r_pend_target;
    logic [31:0] w_pend_target_d;
    logic        r_pend_is_jump;  // source of the parked redirect: 1 = jump, 0 = branch
    logic        w_pend_is_jump_d;
    logic [31:0] r_ifid_instr;
    logic [31:0] w_ifid_instr_d;
    logic [31:0] r_ifid_pc4;
    logic [31:0] w_ifid_pc4_d;
    logic        r_ifid_valid;
    logic        w_ifid_valid_d;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc4;

    assign w_redirect = i_branch_taken | i_jump;
    // Branch resolves later in the pipe, so it is the older instruction and wins.
    assign w_target   = i_branch_taken ? i_branch_target : i_jump_target;
    assign w_pc4      = i_pc_in + 32'd4;

    // Next-PC select and next-state of the FSM, pending redirect and IF/ID register.
    always_comb begin
        o_pc_next        = i_pc_in;
        w_state_d        = r_state;
        w_pend_target_d  = r_pend_target;
        w_pend_is_jump_d = r_pend_is_jump;
        w_ifid_instr_d   = r_ifid_instr;
        w_ifid_pc4_d     = r_ifid_pc4;
        w_ifid_valid_d   = r_ifid_valid;

        if (i_rst) begin
            o_pc_next = RESET_PC;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_redirect) begin
                        w_ifid_valid_d = 1'b0;
                        if (i_imem_ready) begin
                            o_pc_next = w_target;
                        end else begin
                            // Never abort the in-flight fetch; park the target instead.
                            w_pend_target_d  = w_target;
                            w_pend_is_jump_d = ~i_branch_taken;
                            w_state_d        = StHoldRedir;
                        end
                    end else if (i_stall) begin
                        // Load-use hold: PC and IF/ID all keep their values.
                    end else if (!i_imem_ready) begin
                        w_ifid_valid_d = 1'b0;
                    end else begin
                        o_pc_next      = w_pc4;
                        w_ifid_instr_d = i_instr_in;
                        w_ifid_pc4_d   = w_pc4;
                        w_ifid_valid_d = 1'b1;
                    end
                end
                StHoldRedir: begin
                    // Whatever returns now is wrong-path; stall is irrelevant here.
                    w_ifid_valid_d = 1'b0;
                    if (!i_imem_ready) begin
                        if (i_branch_taken) begin
                            w_pend_target_d  = i_branch_target;
                            w_pend_is_jump_d = 1'b0;
                        end else if (i_jump && r_pend_is_jump) begin
                            w_pend_target_d  = i_jump_target;
                            w_pend_is_jump_d = 1'b1;
                        end
                    end else begin
                        o_pc_next = i_branch_taken ? i_branch_target : r_pend_target;
                        w_state_d = StRun;
                    end
                end
                default: begin
                    w_state_d = StRun;
                end
            endcase
        end
    end

    // State, pending redirect and IF/ID registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StRun;
            r_pend_target  <= 32'd0;
            r_pend_is_jump <= 1'b0;
            r_ifid_instr   <= 32'd0;
            r_ifid_pc4     <= 32'd0;
            r_ifid_valid   <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_pend_target  <= w_pend_target_d;
            r_pend_is_jump <= w_pend_is_jump_d;
            r_ifid_instr   <= w_ifid_instr_d;
            r_ifid_pc4     <= w_ifid_pc4_d;
            r_ifid_valid   <= w_ifid_valid_d;
        end
    end

    assign o_ifid_instr       = r_ifid_instr;
    assign o_ifid_pc4         = r_ifid_pc4;
    assign o_ifid_valid       = r_ifid_valid;
    assign o_redirect_pending = (r_state == StHoldRedir);

endmodule

// File: tb/tb_fetch_next_pc.sv
// Directed self-checking bench for fetch_next_pc.
module tb_fetch_next_pc;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_next;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        redirect_pending;

    logic        loop_en;
    logic [31:0] pc_reg;
    logic [31:0] pc_drv;

    int n_checks = 0;
    int n_errors = 0;

    fetch_next_pc #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_pc_in            (pc_in),
        .i_instr_in         (instr_in),
        .i_imem_ready       (imem_ready),
        .i_stall            (stall),
        .i_branch_taken     (branch_taken),
        .i_branch_target    (branch_target),
        .i_jump             (jump),
        .i_jump_target      (jump_target),
        .o_pc_next          (pc_next),
        .o_ifid_instr       (ifid_instr),
        .o_ifid_pc4         (ifid_pc4),
        .o_ifid_valid       (ifid_valid),
        .o_redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter model closing the loop when enabled.
    always @(posedge clk) pc_reg <= pc_next;
    assign pc_in    = loop_en ? pc_reg : pc_drv;
    assign instr_in = ~pc_in;  // instruction memory contents: bitwise inverse of address

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; loop_en = 1'b1; imem_ready = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; branch_target = '0; jump_target = '0; pc_drv = '0;
        tick();
        tick();
        n_checks++;
        if (pc_next !== 32'h0) begin
            n_errors++; $display("FAIL reset_pc_next: got %h want %h", pc_next, 32'h0);
        end
        n_checks++;
        if (ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'h0
            || redirect_pending !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_regs: got v=%b pc4=%h ins=%h rp=%b want 0 0 0 0",
                     ifid_valid, ifid_pc4, ifid_instr, redirect_pending);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        rst = 1'b0;
        settle();
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (pc_next !== exp_pc + 32'd4) begin
                n_errors++;
                $display("FAIL seq_pc_next[%0d]: got %h want %h", i, pc_next, exp_pc + 32'd4);
            end
            tick();
            n_checks++;
            if (ifid_valid !== 1'b1 || ifid_pc4 !== exp_pc + 32'd4 || ifid_instr !== ~exp_pc) begin
                n_errors++;
                $display("FAIL seq_ifid[%0d]: got v=%b pc4=%h ins=%h want 1 %h %h", i,
                         ifid_valid, ifid_pc4, ifid_instr, exp_pc + 32'd4, ~exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_stall();
        loop_en = 1'b0;
        pc_drv = 32'h1C;
        settle();
        tick();  // captures 0x1C: pc4=0x20
        pc_drv = 32'h20;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++;
            if (pc_next !== 32'h20) begin
                n_errors++; $display("FAIL stall_pc_next[%0d]: got %h want %h", i, pc_next, 32'h20);
            end
            tick();
            n_checks++;
            if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h20 || ifid_instr !== ~32'h1C) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got v=%b pc4=%h ins=%h want 1 00000020 %h", i,
                         ifid_valid, ifid_pc4, ifid_instr, ~32'h1C);
            end
        end
        stall = 1'b0;
        settle();
        n_checks++;
        if (pc_next !== 32'h24) begin
            n_errors++; $display("FAIL stall_resume: got %h want %h", pc_next, 32'h24);
        end
        tick();
        n_checks++;
        if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h24) begin
            n_errors++;
            $display("FAIL stall_resume_ifid: got v=%b pc4=%h want 1 00000024", ifid_valid, ifid_pc4);
        end
    endtask

    task automatic test_branch_vs_jump();
        pc_drv = 32'h24;
        branch_taken = 1'b1; branch_target = 32'h100;
        jump = 1'b1; jump_target = 32'h200;
        settle();
        n_checks++;
        if (pc_next !== 32'h100) begin
            n_errors++; $display("FAIL bvj_pc_next: got %h want %h", pc_next, 32'h100);
        end
        tick();
        n_checks++;
        if (ifid_valid !== 1'b0 || redirect_pending !== 1'b0) begin
            n_errors++;
            $display("FAIL bvj_bubble: got v=%b rp=%b want 0 0", ifid_valid, redirect_pending);
        end
        branch_taken = 1'b0; jump = 1'b0;
        pc_drv = 32'h100;
        settle();
        n_checks++;
        if (pc_next !== 32'h104) begin
            n_errors++; $display("FAIL bvj_next_seq: got %h want %h", pc_next, 32'h104);
        end
        tick();
        n_checks++;
        if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h104 || ifid_instr !== ~32'h100) begin
            n_errors++;
            $display("FAIL bvj_capture: got v=%b pc4=%h ins=%h want 1 00000104 %h",
                     ifid_valid, ifid_pc4, ifid_instr, ~32'h100);
        end
    endtask

    task automatic test_miss();
        pc_drv = 32'h60;
        imem_ready = 1'b0;
        settle();
        n_checks++;
        if (pc_next !== 32'h60) begin
            n_errors++; $display("FAIL miss_pc_next: got %h want %h", pc_next, 32'h60);
        end
        tick();
        n_checks++;
        if (ifid_valid !== 1'b0 || ifid_pc4 !== 32'h104 || redirect_pending !== 1'b0) begin
            n_errors++;
            $display("FAIL miss_ifid: got v=%b pc4=%h rp=%b want 0 00000104 0",
                     ifid_valid, ifid_pc4, redirect_pending);
        end
        imem_ready = 1'b1;
    endtask

    task automatic test_redirect_during_miss();
        pc_drv = 32'h50;
        imem_ready = 1'b0;
        jump = 1'b1; jump_target = 32'h80;
        settle();
        n_checks++;
        if (pc_next !== 32'h50) begin
            n_errors++; $display("FAIL rdm_hold_pc: got %h want %h", pc_next, 32'h50);
        end
        tick();
        n_checks++;
        if (redirect_pending !== 1'b1 || ifid_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rdm_enter: got rp=%b v=%b want 1 0", redirect_pending, ifid_valid);
        end
        jump = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h40;
        settle();
        n_checks++;
        if (pc_next !== 32'h50) begin
            n_errors++; $display("FAIL rdm_hold_pc2: got %h want %h", pc_next, 32'h50);
        end
        tick();
        branch_taken = 1'b0;
        jump = 1'b1; jump_target = 32'h90;
        tick();
        jump = 1'b0;
        stall = 1'b1;  // ignored while holding a redirect
        tick();
        n_checks++;
        if (redirect_pending !== 1'b1) begin
            n_errors++; $display("FAIL rdm_still_pending: got %b want 1", redirect_pending);
        end
        imem_ready = 1'b1;
        settle();
        n_checks++;
        if (pc_next !== 32'h40) begin
            n_errors++; $display("FAIL rdm_release_pc: got %h want %h", pc_next, 32'h40);
        end
        tick();
        stall = 1'b0;
        n_checks++;
        if (redirect_pending !== 1'b0 || ifid_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rdm_exit: got rp=%b v=%b want 0 0", redirect_pending, ifid_valid);
        end
        pc_drv = 32'h40;
        settle();
        tick();
        n_checks++;
        if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h44) begin
            n_errors++;
            $display("FAIL rdm_target_fetch: got v=%b pc4=%h want 1 00000044", ifid_valid, ifid_pc4);
        end
    endtask

    task automatic test_hold_branch_on_ready();
        // Pending jump, then a branch arrives in the same cycle memory returns.
        pc_drv = 32'h30;
        imem_ready = 1'b0;
        jump = 1'b1; jump_target = 32'h300;
        tick();
        jump = 1'b0;
        imem_ready = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h400;
        settle();
        n_checks++;
        if (pc_next !== 32'h400) begin
            n_errors++; $display("FAIL hold_new_branch: got %h want %h", pc_next, 32'h400);
        end
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if (redirect_pending !== 1'b0) begin
            n_errors++; $display("FAIL hold_new_branch_exit: got %b want 0", redirect_pending);
        end
    endtask

    task automatic test_wrap();
        pc_drv = 32'hFFFF_FFFC;
        settle();
        n_checks++;
        if (pc_next !== 32'h0) begin
            n_errors++; $display("FAIL wrap_pc_next: got %h want %h", pc_next, 32'h0);
        end
        tick();
        n_checks++;
        if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'h3) begin
            n_errors++;
            $display("FAIL wrap_ifid: got v=%b pc4=%h ins=%h want 1 00000000 00000003",
                     ifid_valid, ifid_pc4, ifid_instr);
        end
    endtask

    task automatic test_reset_mid_hold();
        pc_drv = 32'h70;
        imem_ready = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if (redirect_pending !== 1'b1) begin
            n_errors++; $display("FAIL rmh_enter: got %b want 1", redirect_pending);
        end
        rst = 1'b1;
        imem_ready = 1'b1;
        settle();
        n_checks++;
        if (pc_next !== 32'h0) begin
            n_errors++; $display("FAIL rmh_reset_pc: got %h want %h", pc_next, 32'h0);
        end
        tick();
        n_checks++;
        if (redirect_pending !== 1'b0 || ifid_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rmh_cleared: got rp=%b v=%b want 0 0", redirect_pending, ifid_valid);
        end
        rst = 1'b0;
        pc_drv = 32'h0;
        settle();
        n_checks++;
        if (pc_next !== 32'h4) begin
            n_errors++; $display("FAIL rmh_no_stale_target: got %h want %h", pc_next, 32'h4);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_vs_jump();
        test_miss();
        test_redirect_during_miss();
        test_hold_branch_on_ready();
        test_wrap();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
